// File: rtl/sw_input_conditioner.sv
// Slide-switch conditioner: per-bit multi-flop synchronizer, stability counter
// debounce, and registered one-cycle rise/fall event pulses.
module sw_input_conditioner #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned CNT_W       = $clog2(DB_CYCLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] io_sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o,
    output logic             sw_changed_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_bits;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    always_comb begin
        sync_d[0] = sw_raw_i;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_bits = sync_q[SYNC_STAGES-1];

    // Counter only runs while the synchronized bit disagrees with the stable
    // value; reaching CNT_MAX commits the new value, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync_bits[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync_bits[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync_bits[i];
                fall_d[i]   = ~sync_bits[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign io_sw_o      = stable_q;
    assign sw_rise_o    = rise_q;
    assign sw_fall_o    = fall_q;
    assign sw_changed_o = changed_q;

endmodule
